// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the truth-table checker: FSM state encoding,
// table dimensions and the signature MISR polynomial.
package tt_chk_pkg;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 10;
  localparam int NUM_VEC = 16;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] data);
    return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data;
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and its controller / logic block.
// sig_out exists only when TT_CHK_SIGNATURE_EN is defined.
interface truth_table_checker_if;
  import tt_chk_pkg::*;

  logic               start;
  logic [NUM_IN-1:0]  vec_out;
  logic [NUM_OUT-1:0] resp_in;
  logic               exp_wr_en;
  logic [NUM_IN-1:0]  exp_wr_addr;
  logic [NUM_OUT-1:0] exp_wr_data;
  logic               busy;
  logic               done;
  logic               pass;
  logic [4:0]         err_count;
  logic [NUM_IN-1:0]  first_err_idx;
  logic [NUM_OUT-1:0] first_err_mask;
`ifdef TT_CHK_SIGNATURE_EN
  logic [15:0]        sig_out;

  modport master (
    output start, resp_in, exp_wr_en, exp_wr_addr, exp_wr_data,
    input  vec_out, busy, done, pass, err_count, first_err_idx, first_err_mask, sig_out
  );
  modport slave (
    input  start, resp_in, exp_wr_en, exp_wr_addr, exp_wr_data,
    output vec_out, busy, done, pass, err_count, first_err_idx, first_err_mask, sig_out
  );
`else
  modport master (
    output start, resp_in, exp_wr_en, exp_wr_addr, exp_wr_data,
    input  vec_out, busy, done, pass, err_count, first_err_idx, first_err_mask
  );
  modport slave (
    input  start, resp_in, exp_wr_en, exp_wr_addr, exp_wr_data,
    output vec_out, busy, done, pass, err_count, first_err_idx, first_err_mask
  );
`endif

endinterface

// File: rtl/truth_table_checker_exp_mem.sv
// Expected-response table: 16x10 register file, synchronous write,
// combinational read, no reset (contents survive a checker reset).
module tt_exp_mem
  import tt_chk_pkg::*;
(
  input  logic               clk,
  input  logic               wr_en,
  input  logic [NUM_IN-1:0]  wr_addr,
  input  logic [NUM_OUT-1:0] wr_data,
  input  logic [NUM_IN-1:0]  rd_addr,
  output logic [NUM_OUT-1:0] rd_data
);

  logic [NUM_OUT-1:0] mem [NUM_VEC];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive 4-input truth-table checker: sweeps all 16 vectors, compares the
// 10-bit response against a stored table. Optional MISR via TT_CHK_SIGNATURE_EN.
module truth_table_checker
  import tt_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_checker_if.slave bus
);

  state_t             state, state_nxt;
  logic [NUM_IN-1:0]  idx;
  logic [3:0]         cnt;
  logic [4:0]         err_count;
  logic [NUM_IN-1:0]  first_err_idx;
  logic [NUM_OUT-1:0] first_err_mask;
  logic [NUM_OUT-1:0] exp_rd;
  logic [NUM_OUT-1:0] mask;
  logic               accept;
  logic               settle_end;
  logic               last_vec;
  logic               wr_en;

  assign accept     = (state == ST_IDLE) && bus.start;
  assign settle_end = (cnt == 4'(SETTLE_CYCLES - 1));
  assign last_vec   = (idx == NUM_IN'(NUM_VEC - 1));
  assign mask       = bus.resp_in ^ exp_rd;
  // Table writes only land while idle; reset blocks them too.
  assign wr_en      = (state == ST_IDLE) && bus.exp_wr_en && !rst;

  tt_exp_mem u_exp_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (bus.exp_wr_addr),
    .wr_data (bus.exp_wr_data),
    .rd_addr (idx),
    .rd_data (exp_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_end) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = last_vec ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.vec_out = '0;
    case (state)
      ST_SETTLE, ST_SAMPLE: begin
        bus.busy    = 1'b1;
        bus.vec_out = idx;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      cnt            <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          idx            <= '0;
          cnt            <= '0;
          err_count      <= '0;
          first_err_idx  <= '0;
          first_err_mask <= '0;
        end
        ST_SETTLE: cnt <= cnt + 4'd1;
        ST_SAMPLE: begin
          cnt <= '0;
          if (!last_vec) idx <= idx + NUM_IN'(1);
          if (mask != '0) begin
            err_count <= err_count + 5'd1;
            // Only the first mismatch of the sweep is recorded.
            if (err_count == '0) begin
              first_err_idx  <= idx;
              first_err_mask <= mask;
            end
          end
        end
        ST_DONE: idx <= '0;
        default: ;
      endcase
    end
  end

  assign bus.pass           = (err_count == '0);
  assign bus.err_count      = err_count;
  assign bus.first_err_idx  = first_err_idx;
  assign bus.first_err_mask = first_err_mask;

`ifdef TT_CHK_SIGNATURE_EN
  logic [15:0] sig;

  always_ff @(posedge clk) begin
    if (rst || accept)            sig <= MISR_SEED;
    else if (state == ST_SAMPLE)  sig <= misr_next(sig, {6'b0, bus.resp_in});
  end

  assign bus.sig_out = sig;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: loopback logic block, directed
// table corruptions and injected response faults.
module tb_truth_table_checker;

  localparam int SETTLE   = 4;
  localparam int DONE_OFS = 16 * (SETTLE + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_checker_if bus ();

  truth_table_checker #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic       inj_en;
  logic [3:0] inj_idx;
  logic [9:0] inj_mask;
  assign bus.resp_in = {6'b0, bus.vec_out} ^
                       ((inj_en && bus.vec_out == inj_idx) ? inj_mask : 10'h000);

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  typedef struct {
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  fidx;
    logic [9:0]  fmask;
    int          done_cyc;
    logic [15:0] sig;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] misr_model(input logic on, input logic [3:0] ii, input logic [9:0] im);
    logic [15:0] s;
    logic [9:0]  r;
    s = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      r = 10'(i);
      if (on && ii == 4'(i)) r = r ^ im;
      s = s[15] ? ({s[14:0], 1'b0} ^ 16'h1021) : {s[14:0], 1'b0};
      s = s ^ {6'b0, r};
    end
    return s;
  endfunction

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        chk("pass", 32'(bus.pass), 32'(e.pass));
        chk("err_count", 32'(bus.err_count), 32'(e.err));
        chk("first_err_idx", 32'(bus.first_err_idx), 32'(e.fidx));
        chk("first_err_mask", 32'(bus.first_err_mask), 32'(e.fmask));
`ifdef TT_CHK_SIGNATURE_EN
        chk("sig_out", 32'(bus.sig_out), 32'(e.sig));
`endif
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [9:0] d);
    @(negedge clk);
    bus.exp_wr_en   = 1'b1;
    bus.exp_wr_addr = a;
    bus.exp_wr_data = d;
    @(negedge clk);
    bus.exp_wr_en   = 1'b0;
  endtask

  // Returns cycle number of the accepting edge; pushes expectation if asked.
  task automatic start_sweep(input logic push, input logic p, input logic [4:0] e,
                             input logic [3:0] fi, input logic [9:0] fm, output int t0);
    exp_t x;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t0 = cyc;
    if (push) begin
      x.pass = p; x.err = e; x.fidx = fi; x.fmask = fm;
      x.done_cyc = t0 + DONE_OFS;
      x.sig = misr_model(inj_en, inj_idx, inj_mask);
      sb.push_back(x);
    end
  endtask

  task automatic wait_done(input string nm);
    int seen;
    int k;
    seen = n_done;
    k = 0;
    while (n_done == seen && k < 200) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (n_done == seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.exp_wr_en = 1'b0;
    bus.exp_wr_addr = '0;
    bus.exp_wr_data = '0;
    inj_en = 1'b0; inj_idx = '0; inj_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_vec", 32'(bus.vec_out), 32'd0);
    chk("rst_err", 32'(bus.err_count), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd1);
    chk("rst_fmask", 32'(bus.first_err_mask), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) wr(4'(i), 10'(i));

    // Clean loopback; also spot-check the stimulus during the sweep.
    start_sweep(1'b1, 1'b1, 5'd0, 4'd0, 10'h000, t0);
    repeat (6) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_vec", 32'(bus.vec_out), 32'd1);
    wait_done("pass_case");
    repeat (3) @(negedge clk);
    chk("hold_pass", 32'(bus.pass), 32'd1);

    // exp[5] bit2 flipped
    wr(4'd5, 10'h001);
    start_sweep(1'b1, 1'b0, 5'd1, 4'd5, 10'h004, t0);
    wait_done("single_err");
    repeat (2) @(negedge clk);
    chk("hold_err", 32'(bus.err_count), 32'd1);
    chk("hold_fidx", 32'(bus.first_err_idx), 32'd5);
    wr(4'd5, 10'h005);

    // exp[3] and exp[12] corrupted
    wr(4'd3, 10'h203);
    wr(4'd12, 10'h01D);
    start_sweep(1'b1, 1'b0, 5'd2, 4'd3, 10'h200, t0);
    wait_done("two_err");
    wr(4'd3, 10'h003);
    wr(4'd12, 10'h00C);

    // start and table write during a sweep are both ignored
    start_sweep(1'b1, 1'b1, 5'd0, 4'd0, 10'h000, t0);
    repeat (19) @(negedge clk);
    bus.start = 1'b1;
    bus.exp_wr_en = 1'b1; bus.exp_wr_addr = 4'd0; bus.exp_wr_data = 10'h3FF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.exp_wr_en = 1'b0;
    wait_done("ignored_req");

    // start with a simultaneous write: sweep sees the new exp[7]
    @(negedge clk);
    bus.exp_wr_en = 1'b1; bus.exp_wr_addr = 4'd7; bus.exp_wr_data = 10'h087;
    start_sweep(1'b1, 1'b0, 5'd1, 4'd7, 10'h080, t0);
    bus.exp_wr_en = 1'b0;
    wait_done("start_and_write");
    wr(4'd7, 10'h007);

    // reset mid-sweep after one mismatch has been counted
    inj_en = 1'b1; inj_idx = 4'd3; inj_mask = 10'h001;
    start_sweep(1'b0, 1'b0, 5'd0, 4'd0, 10'h000, t0);
    repeat (29) @(negedge clk);
    chk("pre_rst_err", 32'(bus.err_count), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_vec", 32'(bus.vec_out), 32'd0);
    chk("abort_err", 32'(bus.err_count), 32'd0);
    chk("abort_pass", 32'(bus.pass), 32'd1);
    inj_en = 1'b0;
    repeat (100) @(negedge clk);
    start_sweep(1'b1, 1'b1, 5'd0, 4'd0, 10'h000, t0);
    wait_done("rerun");

`ifdef TT_CHK_SIGNATURE_EN
    begin
      logic [15:0] s_clean, s_bad;
      start_sweep(1'b1, 1'b1, 5'd0, 4'd0, 10'h000, t0);
      wait_done("sig_clean");
      s_clean = bus.sig_out;
      inj_en = 1'b1; inj_idx = 4'd9; inj_mask = 10'h008;
      start_sweep(1'b1, 1'b0, 5'd1, 4'd9, 10'h008, t0);
      wait_done("sig_fault");
      inj_en = 1'b0;
      s_bad = bus.sig_out;
      chk("sig_differs", 32'(s_clean != s_bad), 32'd1);
      repeat (3) @(negedge clk);
      chk("sig_held", 32'(bus.sig_out), 32'(s_bad));
    end
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
